dcache_perf_monitor: RTL and testbench

//  Cycle-accurate, synthesizable event monitor for the L1 dcache/CPU interface. Sits beside CPU.dcache and taps
//  its request, stall, FSM-idle and dirty signals. Classifies each access as read/write hit/miss and counts

---
 rtl/dcache_perf_monitor_pkg.sv | 13 +
 rtl/dcache_perf_monitor_counter.sv | 27 ++
 rtl/dcache_perf_monitor.sv | 102 ++++++++++
 tb/tb_dcache_perf_monitor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_perf_monitor_pkg.sv
// Shared definitions for the dcache performance monitor: counter indices, which
// double as the cnt_o select codes.
package dcache_perf_monitor_pkg;
  localparam int EV_RD_HIT    = 0;
  localparam int EV_RD_MISS   = 1;
  localparam int EV_WR_HIT    = 2;
  localparam int EV_WR_MISS   = 3;
  localparam int EV_WRITEBACK = 4;
  localparam int EV_STALL     = 5;
  localparam int EV_CYCLE     = 6;
  localparam int EV_ACCESS    = 7;
  localparam int EV_NUM       = 8;
endpackage

// File: rtl/dcache_perf_monitor_counter.sv
// Single event counter with synchronous clear and optional saturation at all-ones.
module perf_counter #(
  parameter int W   = 32,
  parameter bit SAT = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) q_d = '0;
    else if (en_i && inc_i && !(SAT && (&q_q))) q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/dcache_perf_monitor.sv
// Classifies dcache accesses into hit/miss/write-back events, counts them, and
// raises a one-shot flush plus sticky done once the cycle budget is spent.
module dcache_perf_monitor
  import dcache_perf_monitor_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned CYCLE_LIMIT = 150,
  parameter bit          SAT         = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             stall_i,
  input  logic             idle_i,
  input  logic             dirty_i,
  input  logic [2:0]       sel_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cycle_o,
  output logic             flush_o,
  output logic             done_o
);
  // Limit compare is done at >=32 bits so a narrow counter never aliases the limit.
  localparam int LW = (CNT_W > 32) ? CNT_W : 32;

  logic [EV_NUM-1:0]            inc;
  logic [EV_NUM-1:0][CNT_W-1:0] cnt;
  logic                         in_miss_q, in_miss_d;
  logic                         flush_q, flush_d;
  logic                         done_q, done_d;
  logic [CNT_W-1:0]             cnt_q;
  logic                         any_acc, miss_entry, hit, at_limit, past_limit, run;

  assign any_acc    = mem_read_i | mem_write_i;
  assign miss_entry = stall_i & idle_i & any_acc;
  assign hit        = !stall_i & !in_miss_q & any_acc;
  assign at_limit   = LW'(cnt[EV_CYCLE]) == LW'(CYCLE_LIMIT);
  assign past_limit = LW'(cnt[EV_CYCLE]) >  LW'(CYCLE_LIMIT);
  assign run        = start_i & !done_q & !past_limit & !clear_i;

  always_comb begin
    inc               = '0;
    inc[EV_WR_MISS]   = miss_entry & mem_write_i;
    inc[EV_RD_MISS]   = miss_entry & !mem_write_i;
    inc[EV_WRITEBACK] = miss_entry & dirty_i;
    inc[EV_WR_HIT]    = hit & mem_write_i;
    inc[EV_RD_HIT]    = hit & !mem_write_i & mem_read_i;
    inc[EV_STALL]     = stall_i;
    inc[EV_CYCLE]     = 1'b1;
    inc[EV_ACCESS]    = miss_entry | hit;
  end

  always_comb begin
    in_miss_d = in_miss_q;
    flush_d   = 1'b0;
    done_d    = done_q;
    if (clear_i) begin
      in_miss_d = 1'b0;
      done_d    = 1'b0;
    end else if (start_i && !done_q) begin
      if (past_limit) begin
        done_d = 1'b1;
      end else begin
        if (miss_entry)    in_miss_d = 1'b1;
        else if (!stall_i) in_miss_d = 1'b0;
        flush_d = at_limit;
      end
    end
  end

  for (genvar g = 0; g < EV_NUM; g++) begin : g_cnt
    perf_counter #(.W(CNT_W), .SAT(SAT)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (inc[g]),
      .clr_i (clear_i),
      .en_i  (run),
      .q_o   (cnt[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_miss_q <= 1'b0;
      flush_q   <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      in_miss_q <= in_miss_d;
      flush_q   <= flush_d;
      done_q    <= done_d;
      cnt_q     <= cnt[sel_i];
    end
  end

  assign cnt_o   = cnt_q;
  assign cycle_o = cnt[EV_CYCLE];
  assign flush_o = flush_q;
  assign done_o  = done_q;
endmodule

// File: tb/tb_dcache_perf_monitor.sv
// Directed bench for dcache_perf_monitor: one full-width instance plus two 4-bit
// instances for saturate/wrap behaviour.
module tb_dcache_perf_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        m_rst, m_start, m_clear, m_rd, m_wr, m_stall, m_idle, m_dirty;
  logic [2:0]  m_sel;
  logic [31:0] m_cnt, m_cycle;
  logic        m_flush, m_done;

  logic        s_rst, s_start, s_rd;
  logic [3:0]  sa_cnt, sa_cycle, wr_cnt, wr_cycle;
  logic        sa_flush, sa_done, wr_flush, wr_done;

  int checks = 0;
  int passes = 0;

  dcache_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(150), .SAT(1'b1)) u_dut (
    .clk_i(clk), .rst_i(m_rst), .start_i(m_start), .clear_i(m_clear),
    .mem_read_i(m_rd), .mem_write_i(m_wr), .stall_i(m_stall), .idle_i(m_idle),
    .dirty_i(m_dirty), .sel_i(m_sel), .cnt_o(m_cnt), .cycle_o(m_cycle),
    .flush_o(m_flush), .done_o(m_done)
  );

  dcache_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(150), .SAT(1'b1)) u_sat (
    .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .clear_i(1'b0),
    .mem_read_i(s_rd), .mem_write_i(1'b0), .stall_i(1'b0), .idle_i(1'b0),
    .dirty_i(1'b0), .sel_i(3'd0), .cnt_o(sa_cnt), .cycle_o(sa_cycle),
    .flush_o(sa_flush), .done_o(sa_done)
  );

  dcache_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(150), .SAT(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .clear_i(1'b0),
    .mem_read_i(s_rd), .mem_write_i(1'b0), .stall_i(1'b0), .idle_i(1'b0),
    .dirty_i(1'b0), .sel_i(3'd0), .cnt_o(wr_cnt), .cycle_o(wr_cycle),
    .flush_o(wr_flush), .done_o(wr_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one access pattern with counting enabled for n cycles.
  task automatic drive(input logic rd, input logic wr, input logic st, input logic idl,
                       input logic dty, input int n);
    m_start = 1'b1; m_rd = rd; m_wr = wr; m_stall = st; m_idle = idl; m_dirty = dty;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold();
    m_start = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_stall = 1'b0; m_idle = 1'b0; m_dirty = 1'b0;
  endtask

  // Counters are frozen while start is low, so the registered mux settles in one edge.
  task automatic chk_cnt(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    m_sel = sel;
    tick();
    chk(tag, m_cnt, exp);
  endtask

  task automatic do_clear();
    m_clear = 1'b1;
    tick();
    m_clear = 1'b0;
  endtask

  initial begin
    m_rst = 1'b1; m_clear = 1'b0; m_sel = 3'd0; hold();
    s_rst = 1'b1; s_start = 1'b0; s_rd = 1'b0;
    tick(); tick();
    chk("rst_cnt", m_cnt, 0);
    chk("rst_cycle", m_cycle, 0);
    chk("rst_flush", {31'd0, m_flush}, 0);
    chk("rst_done", {31'd0, m_done}, 0);
    m_rst = 1'b0; s_rst = 1'b0;
    tick();

    // Read miss: 10 stalled cycles, completion, gap, then a clean read hit.
    drive(1, 0, 1, 1, 0, 1);
    drive(1, 0, 1, 0, 0, 9);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    hold();
    chk_cnt("t1_rd_miss", 3'd1, 1);
    chk_cnt("t1_rd_hit", 3'd0, 1);
    chk_cnt("t1_stall", 3'd5, 10);
    chk_cnt("t1_access", 3'd7, 2);
    chk_cnt("t1_cycle", 3'd6, 13);
    do_clear();
    chk("clr_cycle", m_cycle, 0);

    // Dirty write miss, completion, then three write hits.
    drive(0, 1, 1, 1, 1, 1);
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 3);
    hold();
    chk_cnt("t2_wr_miss", 3'd3, 1);
    chk_cnt("t2_wb", 3'd4, 1);
    chk_cnt("t2_wr_hit", 3'd2, 3);
    chk_cnt("t2_rd_miss", 3'd1, 0);
    chk_cnt("t2_access", 3'd7, 4);
    do_clear();

    // Simultaneous read and write classify as write.
    drive(1, 1, 0, 0, 0, 1);
    hold();
    chk_cnt("t3_wr_hit", 3'd2, 1);
    chk_cnt("t3_rd_hit", 3'd0, 0);
    do_clear();

    // start low mid-miss keeps in_miss, so the completion is still not a hit.
    drive(1, 0, 1, 1, 0, 1);
    hold(); m_rd = 1'b1;
    tick();
    drive(1, 0, 0, 0, 0, 1);
    hold();
    chk_cnt("hold_rd_hit", 3'd0, 0);
    chk_cnt("hold_rd_miss", 3'd1, 1);
    chk_cnt("hold_cycle", 3'd6, 2);
    do_clear();

    // Reset mid-miss clears in_miss; clear wins over a concurrent hit.
    drive(1, 0, 1, 1, 0, 1);
    drive(1, 0, 1, 0, 0, 1);
    m_rst = 1'b1;
    tick();
    m_rst = 1'b0;
    drive(1, 0, 0, 0, 0, 1);
    hold();
    chk_cnt("t6_hit_after_rst", 3'd0, 1);
    m_clear = 1'b1;
    drive(1, 0, 0, 0, 0, 1);
    m_clear = 1'b0;
    hold();
    for (int s = 0; s < 8; s++) chk_cnt($sformatf("t6_zero%0d", s), 3'(s), 0);
    drive(1, 0, 1, 1, 0, 1);
    hold();
    chk_cnt("t6_new_miss", 3'd1, 1);
    chk_cnt("t6_stall", 3'd5, 1);

    // Cycle limit from reset.
    m_rst = 1'b1;
    tick();
    m_rst = 1'b0;
    m_start = 1'b1;
    for (int n = 1; n <= 160; n++) begin
      tick();
      chk($sformatf("t4_flush_c%0d", n), {31'd0, m_flush}, (n == 151) ? 32'd1 : 32'd0);
      chk($sformatf("t4_done_c%0d", n), {31'd0, m_done}, (n >= 152) ? 32'd1 : 32'd0);
    end
    chk("t4_cycle_frozen", m_cycle, 151);
    hold();
    chk_cnt("t4_cnt_cycle", 3'd6, 151);
    do_clear();
    chk("t4_clr_done", {31'd0, m_done}, 0);
    chk("t4_clr_cycle", m_cycle, 0);

    // 4-bit counters: 20 read hits saturate at 15 or wrap to 4.
    s_start = 1'b1; s_rd = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    s_start = 1'b0; s_rd = 1'b0;
    tick();
    chk("t5_sat_rd_hit", {28'd0, sa_cnt}, 15);
    chk("t5_wrap_rd_hit", {28'd0, wr_cnt}, 4);
    chk("t5_sat_cycle", {28'd0, sa_cycle}, 15);
    chk("t5_wrap_cycle", {28'd0, wr_cycle}, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
